pipe_elastic_buf: RTL and testbench

Parametrised elastic buffer that sits between any two CPU pipeline stages (F→D, D→E, E→M, M→W) or in front of the L1 caches. It replaces the single valid/rdy register slice with a DEPTH-entry FIFO carrying an arbitrary payload width. It adds pipeline flush, occupancy count and an almost-full flag. Both sides use the codebase's valid/rdy master/slave handshake, and no combinational path exists from dst_rdy to src_rdy.

---
 rtl/pipe_elastic_buf_pkg.sv | 33 +++
 rtl/pipe_elastic_buf_ctl.sv | 85 ++++++++
 rtl/pipe_elastic_buf.sv | 69 ++++++
 tb/tb_pipe_elastic_buf.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_elastic_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_elastic_buf_pkg
// Description : Per-stage depth / almost-full defaults for pipeline elastic
//               buffers, plus a helper for the default almost-full level.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_elastic_buf_pkg;

  // Generic default used when a stage does not override the buffer depth
  localparam int DEF_BUF_DEPTH     = 4;

  // Per-stage buffer depths
  localparam int F2D_BUF_DEPTH     = 4;
  localparam int D2E_BUF_DEPTH     = 2;
  localparam int E2M_BUF_DEPTH     = 2;
  localparam int M2W_BUF_DEPTH     = 2;
  localparam int L1_REQ_BUF_DEPTH  = 8;

  // Per-stage almost-full levels (one below full unless tuned)
  localparam int F2D_BUF_AF_LEVEL    = F2D_BUF_DEPTH - 1;
  localparam int D2E_BUF_AF_LEVEL    = D2E_BUF_DEPTH - 1;
  localparam int E2M_BUF_AF_LEVEL    = E2M_BUF_DEPTH - 1;
  localparam int M2W_BUF_AF_LEVEL    = M2W_BUF_DEPTH - 1;
  localparam int L1_REQ_BUF_AF_LEVEL = L1_REQ_BUF_DEPTH - 2;

  // Default almost-full threshold: warn one entry before full
  function automatic int af_default(input int depth);
    return depth - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_elastic_buf_ctl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_elastic_buf_ctl
// Description : Control path of the elastic buffer: read/write pointers,
//               occupancy count, registered src_rdy and almost_full.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_elastic_buf_ctl #(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic                         flush_in,
  input  logic                         src_valid,
  input  logic                         dst_rdy,
  output logic                         src_rdy,
  output logic                         dst_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         wr_en,
  output logic [$clog2(DEPTH)-1:0]     wr_ptr,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
  localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_src_rdy;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;

  // Handshake decode and next occupancy; empty/full come from count only
  always_comb begin
    w_push       = src_valid & r_src_rdy;
    w_pop        = (r_count != '0) & dst_rdy;
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Pointer, count and ready state; flush overrides any same-cycle transfer
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_src_rdy <= 1'b0;
    end else if (flush_in) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_src_rdy <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count   <= w_count_next;
      // Ready is registered, so a pop never frees a slot in the same cycle
      r_src_rdy <= (w_count_next < c_depth);
    end
  end

  assign src_rdy     = r_src_rdy;
  assign dst_valid   = (r_count != '0);
  assign count       = r_count;
  assign almost_full = (r_count >= c_af_level);
  assign wr_en       = w_push & ~flush_in;
  assign wr_ptr      = r_wr_ptr;
  assign rd_ptr      = r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/pipe_elastic_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_elastic_buf
// Description : DEPTH-entry elastic FIFO between two valid/rdy pipeline
//               stages with flush, occupancy count and almost-full flag.
//               Storage and read mux live here; control is in the _ctl block.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_elastic_buf
  import pipe_elastic_buf_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = DEF_BUF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic                         flush_in,
  input  logic                         src_valid,
  input  logic [DW-1:0]                src_data,
  output logic                         src_rdy,
  output logic                         dst_valid,
  output logic [DW-1:0]                dst_data,
  input  logic                         dst_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic          w_wr_en;
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;

  pipe_elastic_buf_ctl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_ctl (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .flush_in    (flush_in),
    .src_valid   (src_valid),
    .dst_rdy     (dst_rdy),
    .src_rdy     (src_rdy),
    .dst_valid   (dst_valid),
    .count       (count),
    .almost_full (almost_full),
    .wr_en       (w_wr_en),
    .wr_ptr      (w_wr_ptr),
    .rd_ptr      (w_rd_ptr)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    // One storage entry; cleared on reset so no stale payload is ever shown
    always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
        r_mem[gi] <= '0;
      end else if (w_wr_en && (w_wr_ptr == PW'(gi))) begin
        r_mem[gi] <= src_data;
      end
    end
  end

  // Head of queue is a pure register read, no path from any input
  assign dst_data = r_mem[w_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_pipe_elastic_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_elastic_buf
// Description : Directed self-checking bench for pipe_elastic_buf using
//               DEPTH=4, DEPTH=2 and DEPTH=8 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_elastic_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // DEPTH=4 instance
  logic       flush_a = 1'b0, sv_a = 1'b0, dr_a = 1'b0;
  logic [7:0] sd_a = '0;
  logic       sr_a, dv_a, af_a;
  logic [7:0] dd_a;
  logic [2:0] cnt_a;

  // DEPTH=2 instance
  logic       flush_b = 1'b0, sv_b = 1'b0, dr_b = 1'b0;
  logic [7:0] sd_b = '0;
  logic       sr_b, dv_b, af_b;
  logic [7:0] dd_b;
  logic [1:0] cnt_b;

  // DEPTH=8 instance
  logic       flush_c = 1'b0, sv_c = 1'b0, dr_c = 1'b0;
  logic [7:0] sd_c = '0;
  logic       sr_c, dv_c, af_c;
  logic [7:0] dd_c;
  logic [3:0] cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_elastic_buf #(.DW(8), .DEPTH(4), .AF_LEVEL(3)) dut_a (
    .clk_in(clk), .reset_in(rst_n), .flush_in(flush_a),
    .src_valid(sv_a), .src_data(sd_a), .src_rdy(sr_a),
    .dst_valid(dv_a), .dst_data(dd_a), .dst_rdy(dr_a),
    .count(cnt_a), .almost_full(af_a)
  );

  pipe_elastic_buf #(.DW(8), .DEPTH(2), .AF_LEVEL(1)) dut_b (
    .clk_in(clk), .reset_in(rst_n), .flush_in(flush_b),
    .src_valid(sv_b), .src_data(sd_b), .src_rdy(sr_b),
    .dst_valid(dv_b), .dst_data(dd_b), .dst_rdy(dr_b),
    .count(cnt_b), .almost_full(af_b)
  );

  pipe_elastic_buf #(.DW(8), .DEPTH(8), .AF_LEVEL(7)) dut_c (
    .clk_in(clk), .reset_in(rst_n), .flush_in(flush_c),
    .src_valid(sv_c), .src_data(sd_c), .src_rdy(sr_c),
    .dst_valid(dv_c), .dst_data(dd_c), .dst_rdy(dr_c),
    .count(cnt_c), .almost_full(af_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sv_a = 1'b1; sd_a = 8'h5A;
    tick(); tick();
    n_checks++; if (sr_a !== 1'b0) begin n_fail++; $display("FAIL reset_src_rdy got=%b exp=0", sr_a); end
    n_checks++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL reset_dst_valid got=%b exp=0", dv_a); end
    n_checks++; if (cnt_a !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
    n_checks++; if (dd_a !== 8'h00) begin n_fail++; $display("FAIL reset_dst_data got=%h exp=00", dd_a); end
    n_checks++; if (af_a !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got=%b exp=0", af_a); end
    rst_n = 1'b1;
    #2;
    n_checks++; if (sr_a !== 1'b0) begin n_fail++; $display("FAIL release_src_rdy_early got=%b exp=0", sr_a); end
    tick();
    n_checks++; if (sr_a !== 1'b1) begin n_fail++; $display("FAIL release_src_rdy got=%b exp=1", sr_a); end
    n_checks++; if (cnt_a !== 3'd0) begin n_fail++; $display("FAIL release_no_push count got=%0d exp=0", cnt_a); end
    sv_a = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_seq [5];
    exp_seq[0] = 8'hA0; exp_seq[1] = 8'hA1; exp_seq[2] = 8'hA2;
    exp_seq[3] = 8'hA3; exp_seq[4] = 8'hA4;
    dr_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sv_a = 1'b1; sd_a = 8'hA0 + 8'(i);
      tick();
      n_checks++; if (cnt_a !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, cnt_a, i + 1); end
      n_checks++; if (af_a !== ((i + 1) >= 3)) begin n_fail++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, af_a, (i + 1) >= 3); end
    end
    n_checks++; if (sr_a !== 1'b0) begin n_fail++; $display("FAIL full_src_rdy got=%b exp=0", sr_a); end
    sd_a = 8'hA4;
    tick(); tick();
    n_checks++; if (cnt_a !== 3'd4) begin n_fail++; $display("FAIL full_hold_count got=%0d exp=4", cnt_a); end
    n_checks++; if (sr_a !== 1'b0) begin n_fail++; $display("FAIL full_hold_src_rdy got=%b exp=0", sr_a); end
    dr_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (dv_a !== 1'b1 || dd_a !== exp_seq[k]) begin n_fail++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", k, dv_a, dd_a, exp_seq[k]); end
      tick();
      if (k == 0) begin
        n_checks++; if (sr_a !== 1'b1 || cnt_a !== 3'd3) begin n_fail++; $display("FAIL first_pop got rdy=%b cnt=%0d exp rdy=1 cnt=3", sr_a, cnt_a); end
      end
      if (k == 1) begin
        sv_a = 1'b0;
        n_checks++; if (cnt_a !== 3'd3) begin n_fail++; $display("FAIL pop_push_count got=%0d exp=3", cnt_a); end
      end
    end
    n_checks++; if (cnt_a !== 3'd0 || dv_a !== 1'b0) begin n_fail++; $display("FAIL drained got cnt=%0d dv=%b exp cnt=0 dv=0", cnt_a, dv_a); end
    dr_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    int bad_data = 0;
    int bad_cnt = 0;
    sv_b = 1'b1; dr_b = 1'b1;
    for (int t = 0; t < 100; t++) begin
      sd_b = 8'(t);
      if (t >= 1) begin
        if (dv_b !== 1'b1 || dd_b !== 8'(t - 1)) begin
          bad_data++;
          if (bad_data <= 5) $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", t, dv_b, dd_b, 8'(t - 1));
        end
      end
      if (dv_b === 1'b1) pops++;
      tick();
      if (cnt_b !== 2'd1) begin
        bad_cnt++;
        if (bad_cnt <= 5) $display("FAIL stream_count[%0d] got=%0d exp=1", t, cnt_b);
      end
    end
    n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL stream_data_total got=%0d bad exp=0", bad_data); end
    n_checks++; if (bad_cnt != 0) begin n_fail++; $display("FAIL stream_count_total got=%0d bad exp=0", bad_cnt); end
    n_checks++; if (pops != 99) begin n_fail++; $display("FAIL stream_pops got=%0d exp=99", pops); end
    sv_b = 1'b0;
    tick();
    n_checks++; if (cnt_b !== 2'd0) begin n_fail++; $display("FAIL stream_drain got=%0d exp=0", cnt_b); end
    dr_b = 1'b0;
  endtask

  task automatic test_wrap_random();
    logic [7:0] q [$];
    int sent = 0, rcvd = 0, errs = 0, cyc = 0;
    while (rcvd < 1000 && cyc < 20000 && errs < 10) begin
      sv_c = (sent < 1000);
      sd_c = 8'($urandom);
      dr_c = ($urandom_range(0, 9) < 6);
      n_checks++;
      if (cnt_c !== 4'(q.size()) || dv_c !== (q.size() != 0) || sr_c !== (q.size() < 8) || cnt_c > 4'd8) begin
        n_fail++; errs++;
        $display("FAIL wrap_state[%0d] got cnt=%0d dv=%b rdy=%b exp cnt=%0d", cyc, cnt_c, dv_c, sr_c, q.size());
      end
      if (dr_c && dv_c) begin
        n_checks++;
        if (q.size() == 0 || dd_c !== q[0]) begin
          n_fail++; errs++;
          $display("FAIL wrap_data[%0d] got=%h exp=%h", rcvd, dd_c, (q.size() != 0) ? q[0] : 8'h00);
        end
        if (q.size() != 0) void'(q.pop_front());
        rcvd++;
      end
      if (sv_c && sr_c) begin
        q.push_back(sd_c);
        sent++;
      end
      tick();
      cyc++;
    end
    n_checks++; if (rcvd != 1000) begin n_fail++; $display("FAIL wrap_received got=%0d exp=1000", rcvd); end
    sv_c = 1'b0; dr_c = 1'b0;
  endtask

  task automatic test_flush();
    dr_a = 1'b0;
    sv_a = 1'b1;
    sd_a = 8'h11; tick();
    sd_a = 8'h22; tick();
    sd_a = 8'h33; tick();
    n_checks++; if (cnt_a !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", cnt_a); end
    flush_a = 1'b1; sd_a = 8'h44; dr_a = 1'b1;
    tick();
    flush_a = 1'b0; sv_a = 1'b0; dr_a = 1'b0;
    n_checks++; if (cnt_a !== 3'd0 || dv_a !== 1'b0 || sr_a !== 1'b1) begin n_fail++; $display("FAIL flush_state got cnt=%0d dv=%b rdy=%b exp 0/0/1", cnt_a, dv_a, sr_a); end
    tick();
    n_checks++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL flush_stays_empty got=%b exp=0", dv_a); end
    sv_a = 1'b1; sd_a = 8'h55;
    tick();
    sv_a = 1'b0;
    n_checks++; if (cnt_a !== 3'd1 || dd_a !== 8'h55) begin n_fail++; $display("FAIL flush_next_head got cnt=%0d data=%h exp 1/55", cnt_a, dd_a); end
    dr_a = 1'b1;
    tick();
    dr_a = 1'b0;
    n_checks++; if (cnt_a !== 3'd0 || dv_a !== 1'b0) begin n_fail++; $display("FAIL flush_final got cnt=%0d dv=%b exp 0/0", cnt_a, dv_a); end
  endtask

  task automatic test_mid_reset();
    dr_a = 1'b0; sv_a = 1'b1;
    sd_a = 8'h66; tick();
    sd_a = 8'h77; tick();
    sv_a = 1'b0;
    n_checks++; if (cnt_a !== 3'd2) begin n_fail++; $display("FAIL mreset_pre_count got=%0d exp=2", cnt_a); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (cnt_a !== 3'd0 || dv_a !== 1'b0 || dd_a !== 8'h00 || sr_a !== 1'b0 || af_a !== 1'b0) begin
      n_fail++; $display("FAIL mreset_async got cnt=%0d dv=%b data=%h rdy=%b af=%b exp 0/0/00/0/0", cnt_a, dv_a, dd_a, sr_a, af_a);
    end
    tick();
    rst_n = 1'b1;
    dr_a = 1'b1;
    tick();
    n_checks++; if (sr_a !== 1'b1 || dv_a !== 1'b0) begin n_fail++; $display("FAIL mreset_release got rdy=%b dv=%b exp 1/0", sr_a, dv_a); end
    tick();
    n_checks++; if (dv_a !== 1'b0 || dd_a !== 8'h00) begin n_fail++; $display("FAIL mreset_no_old got dv=%b data=%h exp 0/00", dv_a, dd_a); end
    dr_a = 1'b0; sv_a = 1'b1; sd_a = 8'h88;
    tick();
    sv_a = 1'b0;
    n_checks++; if (cnt_a !== 3'd1 || dd_a !== 8'h88) begin n_fail++; $display("FAIL mreset_new_head got cnt=%0d data=%h exp 1/88", cnt_a, dd_a); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_wrap_random();
    test_flush();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
